// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between execute (port 0) and branch helper (port 1).
// Optional grant counters are compiled in with the ALU_ARB_STATS_EN macro.
package alu_arbiter_pkg;
    typedef enum logic [3:0] {
        ADD  = 4'd0,
        SUB  = 4'd1,
        AND  = 4'd2,
        OR   = 4'd3,
        XOR  = 4'd4,
        SLL  = 4'd5,
        SRL  = 4'd6,
        SRA  = 4'd7,
        SLT  = 4'd8,
        SLTU = 4'd9,
        BEQ  = 4'd10,
        BNE  = 4'd11,
        BLT  = 4'd12,
        BGE  = 4'd13,
        BLTU = 4'd14,
        BGEU = 4'd15
    } ALUControl_Enum;
endpackage

module alu_arbiter_alu
    import alu_arbiter_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  ALUControl_Enum     i_ctrl,
    input  logic [WIDTH-1:0]   i_op1,
    input  logic [WIDTH-1:0]   i_op2,
    output logic [WIDTH-1:0]   o_result,
    output logic               o_branch
);
    localparam int SHAMT_W = $clog2(WIDTH);

    logic signed [WIDTH-1:0] w_op1_s;
    logic signed [WIDTH-1:0] w_op2_s;
    logic [SHAMT_W-1:0]      w_shamt;
    logic [WIDTH-1:0]        w_diff;

    assign w_op1_s = i_op1;
    assign w_op2_s = i_op2;
    assign w_shamt = i_op2[SHAMT_W-1:0];
    assign w_diff  = i_op1 - i_op2;

    function automatic logic branch_taken(input ALUControl_Enum ctrl,
                                          input logic [WIDTH-1:0] a,
                                          input logic [WIDTH-1:0] b);
        logic signed [WIDTH-1:0] a_s;
        logic signed [WIDTH-1:0] b_s;
        a_s = a;
        b_s = b;
        case (ctrl)
            BEQ:     branch_taken = (a == b);
            BNE:     branch_taken = (a != b);
            BLT:     branch_taken = (a_s < b_s);
            BGE:     branch_taken = (a_s >= b_s);
            BLTU:    branch_taken = (a < b);
            BGEU:    branch_taken = (a >= b);
            default: branch_taken = 1'b0;
        endcase
    endfunction

    // Branch compares also return the difference so the helper path can reuse it.
    always_comb begin
        o_result = '0;
        o_branch = branch_taken(i_ctrl, i_op1, i_op2);
        case (i_ctrl)
            ADD:     o_result = i_op1 + i_op2;
            SUB:     o_result = w_diff;
            AND:     o_result = i_op1 & i_op2;
            OR:      o_result = i_op1 | i_op2;
            XOR:     o_result = i_op1 ^ i_op2;
            SLL:     o_result = i_op1 << w_shamt;
            SRL:     o_result = i_op1 >> w_shamt;
            SRA:     o_result = w_op1_s >>> w_shamt;
            SLT:     o_result = {{(WIDTH-1){1'b0}}, (w_op1_s < w_op2_s)};
            SLTU:    o_result = {{(WIDTH-1){1'b0}}, (i_op1 < i_op2)};
            default: o_result = w_diff;
        endcase
    end
endmodule

module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int   WIDTH      = 32,
    parameter logic START_PRIO = 1'b0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req0_valid,
    input  logic [WIDTH-1:0]   req0_op1,
    input  logic [WIDTH-1:0]   req0_op2,
    input  ALUControl_Enum     req0_ctrl,
    output logic               req0_ready,
    input  logic               req1_valid,
    input  logic [WIDTH-1:0]   req1_op1,
    input  logic [WIDTH-1:0]   req1_op2,
    input  ALUControl_Enum     req1_ctrl,
    output logic               req1_ready,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [WIDTH-1:0]   rsp_result,
    output logic               rsp_branch,
    output logic               rsp_id
`ifdef ALU_ARB_STATS_EN
    ,
    input  logic               stats_clr,
    output logic [15:0]        grant_cnt0,
    output logic [15:0]        grant_cnt1
`endif
);
    typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_e;

    state_e             r_state;
    state_e             w_state_nxt;
    logic               r_prio;
    logic [WIDTH-1:0]   r_rsp_result_p1;
    logic               r_rsp_branch_p1;
    logic               r_rsp_id_p1;

    logic               w_any;
    logic               w_winner;
    logic               w_accept_ok;
    logic               w_grant;
    logic [WIDTH-1:0]   w_alu_op1;
    logic [WIDTH-1:0]   w_alu_op2;
    ALUControl_Enum     w_alu_ctrl;
    logic [WIDTH-1:0]   w_alu_result;
    logic               w_alu_branch;

    // Pointer only breaks ties; a lone requester wins regardless of priority.
    assign w_any    = req0_valid | req1_valid;
    assign w_winner = (req0_valid & req1_valid) ? r_prio : req1_valid;

    always_comb begin
        w_state_nxt = r_state;
        w_accept_ok = (r_state == IDLE) | ((r_state == HOLD) & rsp_ready);
        w_grant     = w_accept_ok & w_any & ~rst;
        req0_ready  = w_grant & ~w_winner;
        req1_ready  = w_grant & w_winner;
        rsp_valid   = (r_state == HOLD);
        case (r_state)
            IDLE: begin
                if (w_grant) w_state_nxt = HOLD;
            end
            HOLD: begin
                if (w_grant)        w_state_nxt = HOLD;
                else if (rsp_ready) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_alu_op1  = '0;
        w_alu_op2  = '0;
        w_alu_ctrl = ADD;
        if (w_grant) begin
            w_alu_op1  = w_winner ? req1_op1  : req0_op1;
            w_alu_op2  = w_winner ? req1_op2  : req0_op2;
            w_alu_ctrl = w_winner ? req1_ctrl : req0_ctrl;
        end
    end

    alu_arbiter_alu #(
        .WIDTH    (WIDTH)
    ) u_alu (
        .i_ctrl   (w_alu_ctrl),
        .i_op1    (w_alu_op1),
        .i_op2    (w_alu_op2),
        .o_result (w_alu_result),
        .o_branch (w_alu_branch)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    // Stage p0 -> p1: ALU output captured into the response register on accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_prio          <= START_PRIO;
            r_rsp_result_p1 <= '0;
            r_rsp_branch_p1 <= 1'b0;
            r_rsp_id_p1     <= 1'b0;
        end else if (w_grant) begin
            r_prio          <= ~w_winner;
            r_rsp_result_p1 <= w_alu_result;
            r_rsp_branch_p1 <= w_alu_branch;
            r_rsp_id_p1     <= w_winner;
        end
    end

    assign rsp_result = r_rsp_result_p1;
    assign rsp_branch = r_rsp_branch_p1;
    assign rsp_id     = r_rsp_id_p1;

`ifdef ALU_ARB_STATS_EN
    logic [15:0] r_grant_cnt0;
    logic [15:0] r_grant_cnt1;

    // Clear wins over a same-cycle grant; counters wrap naturally.
    always_ff @(posedge clk) begin
        if (rst || stats_clr) begin
            r_grant_cnt0 <= '0;
            r_grant_cnt1 <= '0;
        end else if (w_grant) begin
            if (w_winner) r_grant_cnt1 <= r_grant_cnt1 + 16'd1;
            else          r_grant_cnt0 <= r_grant_cnt0 + 16'd1;
        end
    end

    assign grant_cnt0 = r_grant_cnt0;
    assign grant_cnt1 = r_grant_cnt1;
`endif
endmodule
